// File: rtl/sram_bist_if.sv
// Bundle of the BIST control/result signals and the SRAM port it drives.
// The master modport is the BIST engine; the slave modport is the host plus the SRAM.
interface sram_bist_if;
    logic       start;
    logic [7:0] pattern;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_count;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;

    modport master (
        input  start, pattern, rdata,
        output we, addr, wdata, busy, done, pass, err_count, fail_addr, fail_data
    );

    modport slave (
        output start, pattern, rdata,
        input  we, addr, wdata, busy, done, pass, err_count, fail_addr, fail_data
    );
endinterface

// File: rtl/sram_bist.sv
// March-style BIST for a 16x8 SRAM: write P ascending, (read P / write ~P) ascending, read ~P descending.
// States: IDLE wait start | W0 write P | RD_A read expect P | WR_A write ~P | R1 read ~P descending | DONE result pulse
module sram_bist (
    input  logic          i_clk,
    input  logic          i_rst,
    sram_bist_if.master   bus
);
    typedef enum logic [2:0] {IDLE, W0, RD_A, WR_A, R1, DONE} state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_idx;
    logic [3:0] w_idx_next;
    logic [7:0] r_pat;
    logic [5:0] r_err_count;
    logic [3:0] r_fail_addr;
    logic [7:0] r_fail_data;
    logic       r_pass;

    logic       w_we;
    logic [3:0] w_addr;
    logic [7:0] w_wdata;
    logic       w_cmp;
    logic [7:0] w_exp;
    logic       w_mismatch;
    logic [5:0] w_err_next;
    logic       w_accept;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Bus outputs depend only on registered state, index and latched pattern.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_we         = 1'b0;
        w_addr       = 4'd0;
        w_wdata      = 8'd0;
        w_cmp        = 1'b0;
        w_exp        = r_pat;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = W0;
                    w_idx_next   = 4'd0;
                end
            end
            W0: begin
                w_we       = 1'b1;
                w_addr     = r_idx;
                w_wdata    = r_pat;
                w_idx_next = r_idx + 4'd1;
                if (r_idx == 4'd15) w_state_next = RD_A;
            end
            RD_A: begin
                w_addr       = r_idx;
                w_cmp        = 1'b1;
                w_exp        = r_pat;
                w_state_next = WR_A;
            end
            WR_A: begin
                w_we    = 1'b1;
                w_addr  = r_idx;
                w_wdata = ~r_pat;
                if (r_idx == 4'd15) begin
                    w_state_next = R1;
                end else begin
                    w_idx_next   = r_idx + 4'd1;
                    w_state_next = RD_A;
                end
            end
            R1: begin
                w_addr = r_idx;
                w_cmp  = 1'b1;
                w_exp  = ~r_pat;
                if (r_idx == 4'd0) w_state_next = DONE;
                else               w_idx_next   = r_idx - 4'd1;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = 4'd0;
            end
        endcase
    end

    assign w_accept   = (r_state == IDLE) && bus.start;
    assign w_mismatch = w_cmp && (bus.rdata != w_exp);
    assign w_err_next = r_err_count + {5'd0, w_mismatch};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pat       <= 8'd0;
            r_err_count <= 6'd0;
            r_fail_addr <= 4'd0;
            r_fail_data <= 8'd0;
            r_pass      <= 1'b0;
        end else if (w_accept) begin
            r_pat       <= bus.pattern;
            r_err_count <= 6'd0;
            r_fail_addr <= 4'd0;
            r_fail_data <= 8'd0;
            r_pass      <= 1'b0;
        end else begin
            if (w_mismatch) begin
                r_err_count <= w_err_next;
                if (r_err_count == 6'd0) begin
                    r_fail_addr <= r_idx;
                    r_fail_data <= bus.rdata;
                end
            end
            // Resolve pass on the final compare so it is already valid during DONE.
            if (r_state == R1 && r_idx == 4'd0) r_pass <= (w_err_next == 6'd0);
        end
    end

    assign bus.we        = w_we;
    assign bus.addr      = w_addr;
    assign bus.wdata     = w_wdata;
    assign bus.busy      = (r_state == W0) || (r_state == RD_A) || (r_state == WR_A) || (r_state == R1);
    assign bus.done      = (r_state == DONE);
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;
    assign bus.fail_addr = r_fail_addr;
    assign bus.fail_data = r_fail_data;
endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: behavioural SRAM with injectable read faults and a March-sequence reference model.
module tb_sram_bist;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_bist_if bus();

    sram_bist dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [7:0] mem [16];
    int         fmode;
    logic [3:0] f_addr;
    logic [7:0] f_mask;
    logic [7:0] f_val;
    int         checks = 0;
    int         errors = 0;

    // fault modes: 0 none, 1 stuck-at-0 bits at f_addr, 2 whole read forced to f_val, 3 stuck-at-1 bits at f_addr
    function automatic logic [7:0] sram_read(input logic [3:0] a, input logic [7:0] d, input int mode,
                                             input logic [3:0] fa, input logic [7:0] fm, input logic [7:0] fv);
        case (mode)
            1:       return (a == fa) ? (d & ~fm) : d;
            2:       return fv;
            3:       return (a == fa) ? (d | fm) : d;
            default: return d;
        endcase
    endfunction

    assign bus.rdata = sram_read(bus.addr, mem[bus.addr], fmode, f_addr, f_mask, f_val);

    always @(posedge clk) if (bus.we === 1'b1) mem[bus.addr] <= bus.wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Walk the March algorithm over a private memory image and tally mismatches.
    task automatic model(input logic [7:0] p, output int e, output logic [3:0] fa, output logic [7:0] fd);
        logic [7:0] m [16];
        logic [7:0] r;
        logic [7:0] np;
        np = ~p;
        e = 0; fa = 4'd0; fd = 8'd0;
        for (int a = 0; a < 16; a++) m[a] = p;
        for (int a = 0; a < 16; a++) begin
            r = sram_read(4'(a), m[a], fmode, f_addr, f_mask, f_val);
            if (r != p) begin
                if (e == 0) begin fa = 4'(a); fd = r; end
                e++;
            end
            m[a] = np;
        end
        for (int a = 15; a >= 0; a--) begin
            r = sram_read(4'(a), m[a], fmode, f_addr, f_mask, f_val);
            if (r != np) begin
                if (e == 0) begin fa = 4'(a); fd = r; end
                e++;
            end
        end
    endtask

    task automatic run_test(input logic [7:0] p, input bit chg, input logic [7:0] p2);
        int         e;
        logic [3:0] fa;
        logic [7:0] fd;
        logic [7:0] np;
        int         a;
        bit         ew;
        np = ~p;
        model(p, e, fa, fd);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.pattern = p;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (k < 16) begin
                a = k; ew = 1'b1;
            end else if (k < 48) begin
                a = (k - 16) / 2; ew = ((k - 16) % 2) == 1;
            end else begin
                a = 15 - (k - 48); ew = 1'b0;
            end
            chk("busy", bus.busy, 1);
            chk("done_early", bus.done, 0);
            chk("we", bus.we, ew);
            chk("addr", bus.addr, a);
            if (ew) chk("wdata", bus.wdata, (k < 16) ? p : np);
            if (chg && k == 4) bus.pattern = p2;
            @(negedge clk);
        end
        chk("done", bus.done, 1);
        chk("busy_done", bus.busy, 0);
        chk("we_done", bus.we, 0);
        chk("addr_done", bus.addr, 0);
        chk("wdata_done", bus.wdata, 0);
        chk("pass", bus.pass, (e == 0));
        chk("err_count", bus.err_count, e);
        chk("fail_addr", bus.fail_addr, fa);
        chk("fail_data", bus.fail_data, fd);
        @(negedge clk);
        chk("done_idle", bus.done, 0);
        chk("busy_idle", bus.busy, 0);
        chk("pass_hold", bus.pass, (e == 0));
        chk("err_hold", bus.err_count, e);
        chk("fail_addr_hold", bus.fail_addr, fa);
        chk("fail_data_hold", bus.fail_data, fd);
    endtask

    initial begin
        int  dn;
        int  bz;
        bit  seen;
        logic [7:0] p;
        for (int a = 0; a < 16; a++) mem[a] = 8'h00;
        fmode = 0; f_addr = 4'd0; f_mask = 8'd0; f_val = 8'd0;
        rst = 1'b1; bus.start = 1'b0; bus.pattern = 8'h00;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_err", bus.err_count, 0);
        chk("rst_fail_addr", bus.fail_addr, 0);
        chk("rst_fail_data", bus.fail_data, 0);

        run_test(8'hA5, 1'b0, 8'h00);

        fmode = 1; f_addr = 4'h3; f_mask = 8'h01;
        run_test(8'hFF, 1'b0, 8'h00);

        fmode = 2; f_val = 8'h00;
        run_test(8'h0F, 1'b0, 8'h00);

        fmode = 0;
        run_test(8'h55, 1'b1, 8'hAA);

        // start held high: one run, then re-accepted in the cycle after DONE
        @(negedge clk);
        bus.pattern = 8'h96;
        bus.start = 1'b1;
        dn = 0; bz = 0;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dn++;
            if (n <= 65 && bus.busy === 1'b1) bz++;
            if (n == 66) chk("held_idle_busy", bus.busy, 0);
            if (n == 67) chk("held_restart_busy", bus.busy, 1);
        end
        chk("held_done_count", dn, 1);
        chk("held_busy_cycles", bz, 64);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("held_second_done", seen, 1);
        chk("held_second_pass", bus.pass, 1);

        // reset in RD_A at idx 7 after a mismatch has been logged
        fmode = 1; f_addr = 4'h2; f_mask = 8'h01;
        p = 8'($urandom) | 8'h01;
        @(negedge clk);
        bus.start = 1'b1; bus.pattern = p;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k < 31; k++) @(negedge clk);
        chk("mid_addr", bus.addr, 7);
        chk("mid_we", bus.we, 0);
        chk("mid_err", bus.err_count, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_we", bus.we, 0);
        chk("mid_rst_addr", bus.addr, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_pass", bus.pass, 0);
        chk("mid_rst_err", bus.err_count, 0);
        chk("mid_rst_fail_addr", bus.fail_addr, 0);
        chk("mid_rst_fail_data", bus.fail_data, 0);
        dn = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
        end
        chk("mid_rst_quiet", dn, 0);
        fmode = 0;
        run_test(8'h3C, 1'b0, 8'h00);

        // start coincident with reset is dropped
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_start_busy0", bus.busy, 0);
        @(negedge clk);
        chk("rst_start_busy1", bus.busy, 0);

        for (int t = 0; t < 6; t++) begin
            fmode  = int'($urandom_range(0, 3));
            f_addr = 4'($urandom);
            f_mask = 8'($urandom) | 8'h10;
            f_val  = 8'($urandom);
            run_test(8'($urandom), 1'b1, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_bist.md
SRAM_BIST -- requirements
Module: sram_bist

Interface
REQ-001 The block SHALL have one parameter: NONE (fixed geometry, 16 words x 8 bits).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have the following ports:
- clk  input  1  rising-edge clock shared with the SRAM.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to begin a test; sampled only in IDLE.
- pattern  input  8  test background; latched on accepted start.
- we  output  1  SRAM write enable.
- addr  output  4  SRAM address.
- wdata  output  8  SRAM write data.
- rdata  input  8  SRAM read data; combinational from addr, same cycle.
- busy  output  1  high from the cycle after an accepted start until DONE.
- done  output  1  one-cycle pulse at end of test.
- pass  output  1  test result, valid from done until next accepted start.
- err_count  output  6  number of read mismatches in the current/last test (0..32).
- fail_addr  output  4  address of the first mismatch.
- fail_data  output  8  rdata observed at the first mismatch.

Function
REQ-004 The FSM SHALL have states IDLE, W0, RD_A, WR_A, R1, DONE, with a 4-bit address counter idx.
REQ-005 IDLE: we=0, busy=0; on start=1, latch P=pattern, clear err_count, fail_addr and fail_data, set idx=0, and go to W0.
REQ-006 W0: we=1, addr=idx, wdata=P; idx increments each cycle; after idx=15, go to RD_A with idx=0 (16 cycles).
REQ-007 RD_A: we=0, addr=idx, compare rdata against P; go to WR_A.
REQ-008 WR_A: we=1, addr=idx, wdata=~P.
- If idx=15, go to R1 with idx=15.
- Otherwise, increment idx and go to RD_A.
- RD_A/WR_A together take 32 cycles.
REQ-009 R1: we=0, addr=idx, compare rdata against ~P; idx decrements each cycle; after idx=0, go to DONE (16 cycles, descending).
REQ-010 DONE: we=0, done=1 for exactly one cycle, pass=(err_count==0); next state IDLE.
REQ-011 Total busy duration SHALL be exactly 64 cycles (W0+RD_A/WR_A+R1); DONE is the 65th cycle after the start cycle.
REQ-012 we, addr and wdata SHALL be decoded from registered state/idx only; there is no combinational path from start or rdata to them.
REQ-013 In IDLE and DONE, addr SHALL be 0 and wdata SHALL be 0.
REQ-014 Mismatch handling: each compare cycle with rdata != expected SHALL increment err_count at the clock edge.
- On the first mismatch only (err_count==0), capture fail_addr=idx and fail_data=rdata.
- Later mismatches do not overwrite these fields.
REQ-015 err_count SHALL NOT wrap; the maximum reachable value is 32, which fits in 6 bits.
REQ-016 start asserted while not in IDLE SHALL be ignored, including in the DONE cycle.
REQ-017 pass, err_count, fail_addr and fail_data SHALL hold their values in IDLE until the next accepted start.
REQ-018 Changes to pattern during a test SHALL have no effect; only the latched P is used.

Reset
REQ-019 When rst=1 at a rising edge, the block SHALL go to IDLE with idx=0, P=0, busy=0, done=0, pass=0, err_count=0, fail_addr=0, fail_data=0, and therefore we=0, addr=0, wdata=0.
REQ-020 Reset SHALL take priority over start and over any in-progress test.
- A reset mid-test aborts the test without a done pulse.
- The SRAM contents are left as-is.
REQ-021 start coincident with rst SHALL be ignored.

Verification
REQ-022 Good memory: pattern=8'hA5, one start pulse.
- Response: 16 writes of A5 to addr 0..15, then 16 read/write pairs (expect A5, write 5A), then reads from 15 down to 0 expecting 5A.
- done on the 65th cycle after start; pass=1; err_count=0.
REQ-023 Stuck bit: force rdata[0]=0 whenever addr=4'h3, pattern=8'hFF.
- Response: mismatch at RD_A addr 3 only (R1 expects 00, so no mismatch there).
- err_count=1, fail_addr=3, fail_data=8'hFE, pass=0.
REQ-024 All-wrong read: rdata forced to 8'h00, pattern=8'h0F.
- Response: 32 mismatches, so err_count=32 with no wrap.
- fail_addr=0, fail_data=8'h00, pass=0.
REQ-025 Busy protocol: start held high for 70 cycles.
- Response: exactly one test runs and done pulses once.
- A second test begins only after returning to IDLE, i.e. start is accepted again in the cycle after DONE.
REQ-026 Mid-test reset: rst=1 for one cycle during RD_A at idx=7.
- Response: next cycle in IDLE with we=0, busy=0, and all result outputs 0; no done pulse.
- A following start with pattern=8'h3C completes with pass=1.
REQ-027 Pattern change: pattern switched from 8'h55 to 8'hAA during W0.
- Response: all writes use 55/AA as latched (55 in W0, AA in WR_A), and pass=1.
